// File: rtl/stack_pkg.sv
// Shared types and default sizing for the CPU operand stack controller.
package stack_pkg;

  localparam int STACK_DATA_W = 8;
  localparam int STACK_DEPTH  = 16;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_TOS  = 2'b11
  } cmd_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RD   = 1'b1
  } state_e;

endpackage

// File: rtl/stack_ram.sv
// Single-port stack storage: synchronous write, registered read, no reset on contents.
module stack_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read register only moves on a read so it stays a clean block-RAM output stage.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_ctrl.sv
// Operand stack controller: PUSH/POP/TOS sequencing over stack_ram, occupancy and error flags.
// Define STACK_ERR_STICKY_EN to make ovf_err/unf_err sticky until err_clr.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] push_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              ovf_err,
  output logic              unf_err,
  input  logic              err_clr
);

  localparam int ADDR_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  sp_q, sp_d, sp_dec;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] ram_rdata;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              ovf_ev, unf_ev;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic              accept;
  cmd_op_e           op;

  assign op     = cmd_op_e'(cmd_op);
  assign sp_dec = sp_q - CNT_W'(1);
  assign empty  = (sp_q == '0);
  assign full   = (sp_q == CNT_W'(DEPTH));
  assign accept = cmd_valid && (state_q == S_IDLE);

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    rsp_data_d = rsp_data_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = sp_q[ADDR_W-1:0];
    ovf_ev     = 1'b0;
    unf_ev     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_PUSH: begin
              if (full) begin
                ovf_ev = 1'b1;
              end else begin
                ram_we = 1'b1;
                sp_d   = sp_q + CNT_W'(1);
              end
            end
            OP_POP, OP_TOS: begin
              if (empty) begin
                unf_ev = 1'b1;
              end else begin
                ram_re   = 1'b1;
                ram_addr = sp_dec[ADDR_W-1:0];
                state_d  = S_RD;
                if (op == OP_POP) begin
                  sp_d = sp_dec;
                end
              end
            end
            default: ;
          endcase
        end
      end
      S_RD: begin
        rsp_data_d = ram_rdata;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef STACK_ERR_STICKY_EN
  // A fresh error beats a simultaneous clear.
  assign ovf_d = ovf_ev | (ovf_q & ~err_clr);
  assign unf_d = unf_ev | (unf_q & ~err_clr);
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  assign ovf_d = ovf_ev;
  assign unf_d = unf_ev;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sp_q       <= '0;
      rsp_data_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      rsp_data_q <= rsp_data_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (push_data),
    .rdata_o (ram_rdata)
  );

  // During RD the fresh RAM word is shown directly; afterwards the captured copy holds it.
  assign rsp_data  = (state_q == S_RD) ? ram_rdata : rsp_data_q;
  assign rsp_valid = (state_q == S_RD);
  assign cmd_ready = (state_q == S_IDLE);
  assign count     = sp_q;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;

endmodule
